// File: rtl/axilite_regbank.sv
// axilite_regbank
//   Small control/status register bank behind a pulse-based request/ack
//   port (the back end of an AXI-lite slave). Word map:
//     0 CTRL     read/write   [15:8] IRQ_MASK, [0] GLOBAL_EN
//     1 STATUS   read-only    returns status_i as sampled at read time
//     2 SCRATCH  read/write   reset value SCRATCH_RESET
//     3 IRQ_PEND write-1-to-clear, [7:0] only
//   Every request is answered by one ack exactly ACK_DELAY cycles later.
//   A write and a read in the same cycle: the write goes first and the read
//   waits in a one-deep pending slot. Each request type has its own slot;
//   a request finding its slot full is dropped.
//
// Handshake: axi_wreq/axi_rreq are single-cycle pulses sampled on the rising
//   edge; there is no back-pressure, so a pulse counts as accepted when it
//   is sampled (unless dropped). axi_wack/axi_rack are single-cycle pulses.
//   Register updates and axi_rdata become visible in the ack cycle, and
//   axi_rdata holds its value until the next read ack.
//
// Ports:
//   axi_clk, axi_rst          clock, asynchronous active-high reset
//   axi_wreq/waddr/wdata      write request, word address, data
//   axi_wack                  write acknowledge
//   axi_rreq/raddr            read request, word address
//   axi_rdata/axi_rack        read data and read acknowledge
//   ctrl_o                    CTRL register contents
//   status_i                  live status word
//   irq_src_i                 level interrupt sources
//   irq_o                     registered interrupt line
//   dbg_state_o               current FSM state (0 IDLE, 1 WR_BUSY, 2 RD_BUSY)
//
// Build option: define AXILITE_REGBANK_IRQ_EN to enable IRQ_PEND, IRQ_MASK
//   and irq_o. Without it, word 3 reads 0, CTRL[15:8] is held at 0, irq_o
//   is 0, and irq_src_i is ignored.
module axilite_regbank #(
  parameter int          ADDR_WIDTH    = 16,
  parameter int          ACK_DELAY     = 2,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  axi_wreq,
  input  logic [ADDR_WIDTH-3:0] axi_waddr,
  input  logic [31:0]           axi_wdata,
  output logic                  axi_wack,
  input  logic                  axi_rreq,
  input  logic [ADDR_WIDTH-3:0] axi_raddr,
  output logic [31:0]           axi_rdata,
  output logic                  axi_rack,
  output logic [31:0]           ctrl_o,
  input  logic [31:0]           status_i,
  input  logic [7:0]            irq_src_i,
  output logic                  irq_o,
  output logic [1:0]            dbg_state_o
);

  localparam int WA    = ADDR_WIDTH - 2;
  localparam int CNT_W = 4;  // holds ACK_DELAY-1 for ACK_DELAY up to 16
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_DELAY - 1);

  localparam logic [WA-1:0] A_CTRL    = WA'(0);
  localparam logic [WA-1:0] A_STATUS  = WA'(1);
  localparam logic [WA-1:0] A_SCRATCH = WA'(2);
  localparam logic [WA-1:0] A_IRQ     = WA'(3);

`ifdef AXILITE_REGBANK_IRQ_EN
  localparam logic [31:0] CTRL_WMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CTRL_WMASK = 32'hFFFF_00FF;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WA-1:0]    r_op_addr, w_op_addr_nxt;
  logic [31:0]      r_op_data, w_op_data_nxt;

  logic             r_wp_vld, w_wp_vld_nxt;
  logic [WA-1:0]    r_wp_addr, w_wp_addr_nxt;
  logic [31:0]      r_wp_data, w_wp_data_nxt;
  logic             r_rp_vld, w_rp_vld_nxt;
  logic [WA-1:0]    r_rp_addr, w_rp_addr_nxt;

  logic             w_live_wr_taken, w_live_rd_taken;
  logic             w_wr_commit, w_rd_commit;
  logic [31:0]      w_rd_value;
  logic [7:0]       w_pend;

  logic             r_wack, r_rack;
  logic [31:0]      r_rdata, r_ctrl, r_scratch;

  // Next-state logic. IDLE serves the pending slots before live requests
  // since they are older. The counter runs ACK_DELAY-1 down to 0 across
  // the busy cycles; the cycle with count 0 is the ack cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_op_addr_nxt   = r_op_addr;
    w_op_data_nxt   = r_op_data;
    w_wp_vld_nxt    = r_wp_vld;
    w_wp_addr_nxt   = r_wp_addr;
    w_wp_data_nxt   = r_wp_data;
    w_rp_vld_nxt    = r_rp_vld;
    w_rp_addr_nxt   = r_rp_addr;
    w_live_wr_taken = 1'b0;
    w_live_rd_taken = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_wp_vld) begin
          w_state_nxt   = S_WR_BUSY;
          w_cnt_nxt     = CNT_LOAD;
          w_op_addr_nxt = r_wp_addr;
          w_op_data_nxt = r_wp_data;
          w_wp_vld_nxt  = 1'b0;
        end else if (r_rp_vld) begin
          w_state_nxt   = S_RD_BUSY;
          w_cnt_nxt     = CNT_LOAD;
          w_op_addr_nxt = r_rp_addr;
          w_rp_vld_nxt  = 1'b0;
        end else if (axi_wreq) begin
          w_state_nxt     = S_WR_BUSY;
          w_cnt_nxt       = CNT_LOAD;
          w_op_addr_nxt   = axi_waddr;
          w_op_data_nxt   = axi_wdata;
          w_live_wr_taken = 1'b1;
        end else if (axi_rreq) begin
          w_state_nxt     = S_RD_BUSY;
          w_cnt_nxt       = CNT_LOAD;
          w_op_addr_nxt   = axi_raddr;
          w_live_rd_taken = 1'b1;
        end
      end
      default: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
    endcase

    // A live request not launched now parks in its slot if that slot is
    // (or is just becoming) free; otherwise it is dropped.
    if (axi_wreq && !w_live_wr_taken && !w_wp_vld_nxt) begin
      w_wp_vld_nxt  = 1'b1;
      w_wp_addr_nxt = axi_waddr;
      w_wp_data_nxt = axi_wdata;
    end
    if (axi_rreq && !w_live_rd_taken && !w_rp_vld_nxt) begin
      w_rp_vld_nxt  = 1'b1;
      w_rp_addr_nxt = axi_raddr;
    end

    // The edge entering the ack cycle applies the write / captures the read.
    w_wr_commit = (w_state_nxt == S_WR_BUSY) && (w_cnt_nxt == '0);
    w_rd_commit = (w_state_nxt == S_RD_BUSY) && (w_cnt_nxt == '0);
  end

  always_comb begin
    w_rd_value = '0;
    case (w_op_addr_nxt)
      A_CTRL:    w_rd_value = r_ctrl;
      A_STATUS:  w_rd_value = status_i;
      A_SCRATCH: w_rd_value = r_scratch;
      A_IRQ:     w_rd_value = {24'h0, w_pend};
      default:   w_rd_value = '0;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_addr <= '0;
      r_op_data <= '0;
      r_wp_vld  <= 1'b0;
      r_wp_addr <= '0;
      r_wp_data <= '0;
      r_rp_vld  <= 1'b0;
      r_rp_addr <= '0;
      r_wack    <= 1'b0;
      r_rack    <= 1'b0;
      r_rdata   <= '0;
      r_ctrl    <= '0;
      r_scratch <= SCRATCH_RESET;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op_addr <= w_op_addr_nxt;
      r_op_data <= w_op_data_nxt;
      r_wp_vld  <= w_wp_vld_nxt;
      r_wp_addr <= w_wp_addr_nxt;
      r_wp_data <= w_wp_data_nxt;
      r_rp_vld  <= w_rp_vld_nxt;
      r_rp_addr <= w_rp_addr_nxt;
      r_wack    <= w_wr_commit;
      r_rack    <= w_rd_commit;
      if (w_rd_commit) r_rdata <= w_rd_value;
      if (w_wr_commit) begin
        case (w_op_addr_nxt)
          A_CTRL:    r_ctrl    <= w_op_data_nxt & CTRL_WMASK;
          A_SCRATCH: r_scratch <= w_op_data_nxt;
          default:   ;
        endcase
      end
    end
  end

`ifdef AXILITE_REGBANK_IRQ_EN
  logic [7:0] r_pend;
  logic [7:0] w_pend_clr;
  logic       r_irq;

  assign w_pend_clr = (w_wr_commit && (w_op_addr_nxt == A_IRQ)) ?
                      w_op_data_nxt[7:0] : 8'h00;

  // Sources are OR-ed in after the clear so an active source wins.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_pend <= 8'h00;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | irq_src_i;
      r_irq  <= r_ctrl[0] & (|(r_pend & r_ctrl[15:8]));
    end
  end

  assign w_pend = r_pend;
  assign irq_o  = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = ^irq_src_i;
  assign w_pend       = 8'h00;
  assign irq_o        = 1'b0;
`endif

  assign axi_wack    = r_wack;
  assign axi_rack    = r_rack;
  assign axi_rdata   = r_rdata;
  assign ctrl_o      = r_ctrl;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_axilite_regbank.sv
`timescale 1ns/1ps
module tb_axilite_regbank;

  localparam int          AW = 16;
  localparam int          WA = AW - 2;
  localparam int          D  = 2;
  localparam logic [31:0] SR = 32'h5C2A_7C11;
`ifdef AXILITE_REGBANK_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_00FF;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wreq = 1'b0, rreq = 1'b0;
  logic [WA-1:0] waddr = '0, raddr = '0;
  logic [31:0]   wdata = '0, status_i = '0;
  logic [7:0]    irq_src = '0;
  logic          wack, rack, irq_o;
  logic [31:0]   rdata, ctrl_o;
  logic [1:0]    dbg_state;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axilite_regbank #(.ADDR_WIDTH(AW), .ACK_DELAY(D), .SCRATCH_RESET(SR)) dut (
    .axi_clk(clk), .axi_rst(rst),
    .axi_wreq(wreq), .axi_waddr(waddr), .axi_wdata(wdata), .axi_wack(wack),
    .axi_rreq(rreq), .axi_raddr(raddr), .axi_rdata(rdata), .axi_rack(rack),
    .ctrl_o(ctrl_o), .status_i(status_i), .irq_src_i(irq_src), .irq_o(irq_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0, n_fail = 0;
  int          n_wack = 0, n_rack = 0, exp_n_wack = 0, exp_n_rack = 0;
  int          wr_cyc_q[$];
  int          rd_cyc_q[$];
  logic [31:0] exp_q[$];

  // Reference model of the register map
  logic [31:0] m_ctrl = '0, m_scratch = SR;
  logic [7:0]  m_pend = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [WA-1:0] a, input logic [31:0] st);
    if (a == WA'(0)) return m_ctrl;
    if (a == WA'(1)) return st;
    if (a == WA'(2)) return m_scratch;
    if (a == WA'(3)) return {24'h0, m_pend};
    return 32'h0;
  endfunction

  task automatic m_write(input logic [WA-1:0] a, input logic [31:0] d);
    if (a == WA'(0)) m_ctrl = d & CTRL_MASK;
    if (a == WA'(2)) m_scratch = d;
    if (a == WA'(3)) m_pend = m_pend & ~d[7:0];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (wack) begin
        n_wack++;
        if (wr_cyc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wack_unexpected: got ack at cycle %0d expected none", cyc);
        end else begin
          check("wack_cycle", 32'(cyc), 32'(wr_cyc_q.pop_front()));
        end
      end
      if (rack) begin
        n_rack++;
        if (rd_cyc_q.size() == 0 || exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rack_unexpected: got ack at cycle %0d data %h expected none", cyc, rdata);
        end else begin
          check("rack_cycle", 32'(cyc), 32'(rd_cyc_q.pop_front()));
          check("rack_data", rdata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [WA-1:0] a, input logic [31:0] d);
    tick();
    wreq = 1'b1; waddr = a; wdata = d;
    wr_cyc_q.push_back(cyc + D); exp_n_wack++;
    m_write(a, d);
    tick();
    wreq = 1'b0;
  endtask

  task automatic do_read(input logic [WA-1:0] a);
    tick();
    rreq = 1'b1; raddr = a;
    rd_cyc_q.push_back(cyc + D); exp_n_rack++;
    exp_q.push_back(m_read(a, status_i));
    tick();
    rreq = 1'b0;
  endtask

  task automatic settle();
    repeat (2 * D + 4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wack", 32'(wack), 32'h0);
    check("rst_rack", 32'(rack), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ctrl", ctrl_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Reset values of the map
    for (int a = 0; a < 4; a++) begin
      do_read(WA'(a));
      settle();
    end

    // Scratch write then read back
    do_write(WA'(2), 32'hA5A5_5A5A);
    settle();
    do_read(WA'(2));
    settle();

    // Same-cycle write and read of the same register
    begin
      int n;
      tick();
      wreq = 1'b1; waddr = WA'(2); wdata = 32'h1234_5678;
      rreq = 1'b1; raddr = WA'(2);
      n = cyc;
      wr_cyc_q.push_back(n + D); exp_n_wack++;
      m_write(WA'(2), 32'h1234_5678);
      rd_cyc_q.push_back(n + 2 * D + 1); exp_n_rack++;
      exp_q.push_back(m_read(WA'(2), status_i));
      tick();
      wreq = 1'b0; rreq = 1'b0;
      settle();
    end

    // Read-only and out-of-range accesses
    do_write(WA'(1), 32'hFFFF_FFFF);
    settle();
    do_read(WA'(7));
    settle();
    status_i = 32'h0BAD_F00D;
    do_read(WA'(1));
    settle();
    do_write(WA'(14'h3FFF), 32'h7777_7777);
    settle();
    do_read(WA'(2));
    settle();

    // Back-to-back writes: second parks, third finds the slot full
    begin
      int n;
      tick();
      wreq = 1'b1; waddr = WA'(2); wdata = 32'h0000_0001; n = cyc;
      wr_cyc_q.push_back(n + D); exp_n_wack++;
      m_write(WA'(2), 32'h0000_0001);
      tick();
      wdata = 32'h0000_0002;
      wr_cyc_q.push_back(n + 2 * D + 1); exp_n_wack++;
      m_write(WA'(2), 32'h0000_0002);
      tick();
      wdata = 32'h0000_0003;
      tick();
      wreq = 1'b0;
      settle();
    end
    do_read(WA'(2));
    settle();

    // Back-to-back reads: same parking/dropping rule
    begin
      int n;
      status_i = 32'h1357_9BDF;
      tick();
      rreq = 1'b1; raddr = WA'(0); n = cyc;
      rd_cyc_q.push_back(n + D); exp_n_rack++;
      exp_q.push_back(m_read(WA'(0), status_i));
      tick();
      raddr = WA'(2);
      rd_cyc_q.push_back(n + 2 * D + 1); exp_n_rack++;
      exp_q.push_back(m_read(WA'(2), status_i));
      tick();
      raddr = WA'(1);
      tick();
      rreq = 1'b0;
      settle();
    end

    // Randomized single transactions
    for (int i = 0; i < 40; i++) begin
      logic [WA-1:0] a;
      logic [31:0]   d;
      a = WA'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = WA'($urandom);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d);
        repeat (D + 1) tick();
        check("rand_ctrl_o", ctrl_o, m_ctrl);
      end else begin
        status_i = $urandom;
        do_read(a);
      end
      repeat ($urandom_range(D, D + 3)) tick();
    end
    settle();

`ifdef AXILITE_REGBANK_IRQ_EN
    // Interrupt path: mask bit 0 + global enable
    begin
      do_write(WA'(0), 32'h0000_0101);
      settle();
      tick();
      irq_src = 8'h01;
      tick();
      irq_src = 8'h00;
      m_pend = m_pend | 8'h01;
      check("irq_lat1", 32'(irq_o), 32'h0);
      tick();
      check("irq_lat2", 32'(irq_o), 32'h1);
      do_read(WA'(3));
      settle();
      do_write(WA'(3), 32'h0000_0001);
      tick();
      check("irq_in_ack_cycle", 32'(irq_o), 32'h1);
      tick();
      check("irq_after_clear", 32'(irq_o), 32'h0);
      settle();
    end
`else
    // Interrupt path compiled out: mask bits and pending word read as 0
    begin
      do_write(WA'(0), 32'h0000_FF01);
      settle();
      check("ctrl_mask_bits", ctrl_o, m_ctrl);
      tick();
      irq_src = 8'hFF;
      repeat (3) tick();
      check("irq_off", 32'(irq_o), 32'h0);
      do_write(WA'(3), 32'hFFFF_FFFF);
      settle();
      do_read(WA'(3));
      settle();
      irq_src = 8'h00;
    end
`endif

    // Reset while a write is in flight
    do_write(WA'(0), 32'h0000_0055);
    settle();
    begin
      tick();
      wreq = 1'b1; waddr = WA'(0); wdata = 32'h0000_00AA;
      tick();
      wreq = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_inflight_rdata", rdata, 32'h0);
      rst = 1'b0;
      m_ctrl = '0; m_scratch = SR; m_pend = '0;
      repeat (3) tick();
      check("rst_inflight_ctrl", ctrl_o, m_ctrl);
    end
    do_read(WA'(2));
    settle();
    do_write(WA'(2), 32'hCAFE_F00D);
    settle();
    do_read(WA'(2));
    settle();

    repeat (10) tick();
    check("wr_queue_empty", 32'(wr_cyc_q.size()), 32'h0);
    check("rd_queue_empty", 32'(rd_cyc_q.size()), 32'h0);
    check("wack_count", 32'(n_wack), 32'(exp_n_wack));
    check("rack_count", 32'(n_rack), 32'(exp_n_rack));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule
